// File: rtl/aes_input_loader.sv
// aes_input_loader: streams a frame into the AES input buffer, appends the sentinel,
// then runs the engine until completion. Define AES_LOADER_PAD_EN for 128-bit block padding.
module aes_input_loader #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] SENTINEL  = 32'hDEADBEEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] s_data_in,
  input  logic        s_valid_in,
  input  logic        s_last_in,
  output logic        s_ready_out,
  input  logic        mode_decrypt_in,
  output logic [3:0]  mem_we_out,
  output logic [9:0]  mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [2:0]  aes_ctrl_out,
  input  logic        aes_complete_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        overflow_err_out,
  output logic        sentinel_err_out
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1;
`ifdef AES_LOADER_PAD_EN
  localparam int unsigned LIM = ((MAX_WORDS - 1) / 4) * 4;
`else
  localparam int unsigned LIM = MAX_WORDS - 1;
`endif
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
`ifdef AES_LOADER_PAD_EN
    PAD   = 3'd2,
`endif
    TERM  = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [9:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             serr_q, serr_d;
  logic             mode_q, mode_d;
  logic             accept;
  logic             last_hit;
  logic [9:0]       wr_addr;

  assign s_ready_out      = (state_q == IDLE) || (state_q == LOAD);
  assign accept           = s_valid_in && s_ready_out;
  assign wr_addr          = 10'(BASE_ADDR + 32'(cnt_q));
  assign busy_out         = (state_q != IDLE);
  assign mem_we_out       = {4{we_q}};
  assign mem_addr_out     = addr_q;
  assign mem_data_out     = data_q;
  assign aes_ctrl_out     = ctrl_q;
  assign done_out         = done_q;
  assign overflow_err_out = ovf_q;
  assign sentinel_err_out = serr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    serr_d   = serr_q;
    mode_d   = mode_q;
    last_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d   = mode_decrypt_in;
          we_d     = 1'b1;
          addr_d   = wr_addr;
          data_d   = s_data_in;
          cnt_d    = CNT_W'(1);
          ovf_d    = 1'b0;
          serr_d   = (s_data_in == SENTINEL);
          state_d  = LOAD;
          last_hit = s_last_in;
        end
      end
      LOAD: begin
        if (accept) begin
          // Beats past the limit are swallowed so the sentinel slot stays free.
          if (cnt_q == LIM_C) begin
            ovf_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = wr_addr;
            data_d = s_data_in;
            cnt_d  = cnt_q + CNT_W'(1);
            if (s_data_in == SENTINEL) serr_d = 1'b1;
          end
          last_hit = s_last_in;
        end
      end
`ifdef AES_LOADER_PAD_EN
      PAD: begin
        we_d   = 1'b1;
        addr_d = wr_addr;
        data_d = 32'h0;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_d[1:0] == 2'b00) state_d = TERM;
      end
`endif
      TERM: begin
        we_d    = 1'b1;
        addr_d  = wr_addr;
        data_d  = SENTINEL;
        state_d = START;
      end
      START: begin
        ctrl_d  = mode_q ? 3'b010 : 3'b001;
        state_d = WAIT;
      end
      WAIT: begin
        if (aes_complete_in) begin
          ctrl_d  = 3'b000;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (last_hit) begin
`ifdef AES_LOADER_PAD_EN
      state_d = (cnt_d[1:0] == 2'b00) ? TERM : PAD;
`else
      state_d = TERM;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 10'(BASE_ADDR);
      data_q  <= 32'h0;
      ctrl_q  <= 3'b000;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader with a write scoreboard; honours AES_LOADER_PAD_EN.
module tb_aes_input_loader;
  localparam logic [31:0] SENT = 32'hDEADBEEF;
`ifdef AES_LOADER_PAD_EN
  localparam int LIM = 252;
`else
  localparam int LIM = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        s_mode;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  aes_ctrl;
  logic        aes_complete;
  logic        busy;
  logic        done;
  logic        ovf_err;
  logic        sent_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] frame_q[$];

  aes_input_loader dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .s_data_in(s_data), .s_valid_in(s_valid), .s_last_in(s_last), .s_ready_out(s_ready),
    .mode_decrypt_in(s_mode),
    .mem_we_out(mem_we), .mem_addr_out(mem_addr), .mem_data_out(mem_data),
    .aes_ctrl_out(aes_ctrl), .aes_complete_in(aes_complete),
    .busy_out(busy), .done_out(done),
    .overflow_err_out(ovf_err), .sentinel_err_out(sent_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every buffer write must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we !== 4'h0) begin
      if (exp_q.size() == 0) begin
        check("write_unexpected", 32'(mem_we), 32'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_we", 32'(mem_we), 32'hF);
        check("write_addr", 32'(mem_addr), 32'(e.a));
        check("write_data", mem_data, e.d);
      end
    end
  end

  task automatic send_frame(input bit dec, input bit gaps);
    int  i = 0;
    int  guard = 0;
    int  cnt_m = 0;
    bit  skip = 1'b0;
    bit  rdy;
    while (i < frame_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (gaps && skip) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'b0;
        skip    = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = frame_q[i];
        s_last  = (i == frame_q.size() - 1);
        s_mode  = (i == 0) ? dec : ~dec;
        rdy     = s_ready;
        @(posedge clk);
        if (rdy) begin
          if (cnt_m < LIM) begin
            exp_q.push_back('{a: 10'(cnt_m), d: frame_q[i]});
            cnt_m++;
          end
          i++;
          skip = gaps;
        end
      end
    end
    check("send_all_beats", 32'(i), 32'(frame_q.size()));
`ifdef AES_LOADER_PAD_EN
    while (cnt_m % 4 != 0) begin
      exp_q.push_back('{a: 10'(cnt_m), d: 32'h0});
      cnt_m++;
    end
`endif
    exp_q.push_back('{a: 10'(cnt_m), d: SENT});
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_ctrl();
    int g = 0;
    while (aes_ctrl === 3'b000 && g < 400) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic finish_frame(input string tag, input logic [2:0] exp_ctrl);
    wait_ctrl();
    check({tag, "_ctrl"}, 32'(aes_ctrl), 32'(exp_ctrl));
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);
    check({tag, "_ctrl_hold"}, 32'(aes_ctrl), 32'(exp_ctrl));
    check({tag, "_busy"}, 32'(busy), 32'h1);
    check({tag, "_done_idle"}, 32'(done), 32'h0);
    aes_complete = 1'b1;
    @(negedge clk);
    check({tag, "_ctrl_drop"}, 32'(aes_ctrl), 32'h0);
    check({tag, "_done_pulse"}, 32'(done), 32'h1);
    aes_complete = 1'b0;
    @(negedge clk);
    check({tag, "_done_end"}, 32'(done), 32'h0);
    check({tag, "_busy_end"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0; aes_complete = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_data", mem_data, 32'h0);
    check("rst_ctrl", 32'(aes_ctrl), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_flags", 32'({ovf_err, sent_err}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Encrypt, 4 words.
    frame_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    send_frame(1'b0, 1'b0);
    finish_frame("enc4", 3'b001);
    check("enc4_flags", 32'({ovf_err, sent_err}), 32'h0);

    // Decrypt, 6 words (pad to 8 when enabled).
    frame_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    send_frame(1'b1, 1'b0);
    finish_frame("dec6", 3'b010);

    // Overflow: 300 beats.
    frame_q.delete();
    for (int k = 0; k < 300; k++) frame_q.push_back(32'h1000 + 32'(k));
    send_frame(1'b0, 1'b0);
    finish_frame("ovf", 3'b001);
    check("ovf_flag", 32'(ovf_err), 32'h1);

    // Sentinel collision at position 2; also clears the overflow flag.
    frame_q = '{32'hA0, 32'hA1, SENT, 32'hA3, 32'hA4};
    send_frame(1'b0, 1'b0);
    finish_frame("coll", 3'b001);
    check("coll_serr", 32'(sent_err), 32'h1);
    check("coll_ovf_cleared", 32'(ovf_err), 32'h0);

    // Gapped stream, decrypt, 7 words.
    frame_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6};
    send_frame(1'b1, 1'b1);
    finish_frame("gap", 3'b010);
    check("gap_serr_cleared", 32'(sent_err), 32'h0);

    // Reset while waiting on the engine.
    frame_q = '{32'hC0, 32'hC1, 32'hC2};
    send_frame(1'b1, 1'b0);
    wait_ctrl();
    check("rstw_ctrl_before", 32'(aes_ctrl), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_ctrl_async", 32'(aes_ctrl), 32'h0);
    check("rstw_busy_async", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    send_frame(1'b0, 1'b0);
    finish_frame("after_rst", 3'b001);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
